// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C bus monitor.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one bus line into the clk domain and flags edges of the
// synchronized value. Flops reset to 1 so an idle bus is assumed.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain followed by the edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: decodes START/STOP, address and data bytes
// from the synchronized SDA/SCL lines and reports them as registered pulses.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_sda,
  input  logic                  i2c_scl,
  output logic                  lines_busy,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  addr_valid,
  output logic [I2C_ADDR_W-1:0] addr,
  output logic                  rw,
  output logic                  byte_valid,
  output logic [I2C_DATA_W-1:0] data_out,
  output logic                  ack,
  output logic                  bus_err
);

  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_scl, w_scl_rise, w_scl_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk(clk), .rst(rst), .i_line(i2c_sda),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .rst(rst), .i_line(i2c_scl),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_state_t            r_state, w_state_n;
  logic [2:0]            r_cnt, w_cnt_n;
  logic [I2C_DATA_W-1:0] r_shift, w_shift_n;
  logic                  r_busy, w_busy_n;
  logic                  r_start, w_start_n;
  logic                  r_stop, w_stop_n;
  logic                  r_av, w_av_n;
  logic                  r_bv, w_bv_n;
  logic                  r_err, w_err_n;
  logic [I2C_ADDR_W-1:0] r_addr, w_addr_n;
  logic                  r_rw, w_rw_n;
  logic [I2C_DATA_W-1:0] r_data, w_data_n;
  logic                  r_ack, w_ack_n;

  logic w_scl_high, w_start, w_stop, w_bit, w_in_byte;

  // SCL high in both the previous and current sample; a simultaneous
  // SDA/SCL change can then never qualify as START, STOP or a bit.
  assign w_scl_high = w_scl & ~w_scl_rise & ~w_scl_fall;
  assign w_start    = w_sda_fall & w_scl_high;
  assign w_stop     = w_sda_rise & w_scl_high;
  assign w_bit      = w_scl_rise & ~w_sda_rise & ~w_sda_fall;
  assign w_in_byte  = (((r_state == ST_ADDR) || (r_state == ST_DATA)) && (r_cnt != 3'd0)) ||
                      (r_state == ST_ADDR_ACK) || (r_state == ST_DATA_ACK);

  // State, counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_av    <= 1'b0;
      r_bv    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_data  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_busy  <= w_busy_n;
      r_start <= w_start_n;
      r_stop  <= w_stop_n;
      r_av    <= w_av_n;
      r_bv    <= w_bv_n;
      r_err   <= w_err_n;
      r_addr  <= w_addr_n;
      r_rw    <= w_rw_n;
      r_data  <= w_data_n;
      r_ack   <= w_ack_n;
    end
  end

  // Next-state and next-output decode; STOP has priority, then START, then bit sampling.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_busy_n  = r_busy;
    w_start_n = 1'b0;
    w_stop_n  = 1'b0;
    w_av_n    = 1'b0;
    w_bv_n    = 1'b0;
    w_err_n   = 1'b0;
    w_addr_n  = r_addr;
    w_rw_n    = r_rw;
    w_data_n  = r_data;
    w_ack_n   = r_ack;
    if (w_stop) begin
      w_stop_n  = 1'b1;
      w_err_n   = w_in_byte;
      w_busy_n  = 1'b0;
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
    end else if (w_start) begin
      w_start_n = 1'b1;
      w_err_n   = w_in_byte;
      w_busy_n  = 1'b1;
      w_state_n = ST_ADDR;
      w_cnt_n   = '0;
    end else if (w_bit) begin
      case (r_state)
        ST_ADDR, ST_DATA: begin
          w_shift_n = {r_shift[I2C_DATA_W-2:0], w_sda};
          if (r_cnt == 3'd7) begin
            w_cnt_n   = '0;
            w_state_n = (r_state == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
          end else begin
            w_cnt_n = r_cnt + 3'd1;
          end
        end
        ST_ADDR_ACK: begin
          w_addr_n  = r_shift[I2C_DATA_W-1:1];
          w_rw_n    = r_shift[0];
          w_ack_n   = ~w_sda;
          w_av_n    = 1'b1;
          w_state_n = w_sda ? ST_IGNORE : ST_DATA;
        end
        ST_DATA_ACK: begin
          w_data_n  = r_shift;
          w_ack_n   = ~w_sda;
          w_bv_n    = 1'b1;
          w_state_n = ST_DATA;
        end
        default: ;
      endcase
    end
  end

  assign lines_busy = r_busy;
  assign start_det  = r_start;
  assign stop_det   = r_stop;
  assign addr_valid = r_av;
  assign byte_valid = r_bv;
  assign bus_err    = r_err;
  assign addr       = r_addr;
  assign rw         = r_rw;
  assign data_out   = r_data;
  assign ack        = r_ack;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: bus-level stimulus against a
// transaction-level reference model of the monitor's decoding rules.
module tb_i2c_bus_monitor;

  localparam int SYNC = 3;
  localparam int LAT  = SYNC + 1;
  localparam int PH   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i2c_sda = 1'b1;
  logic       i2c_scl = 1'b1;
  logic       lines_busy, start_det, stop_det, addr_valid, rw, byte_valid, ack, bus_err;
  logic [6:0] addr;
  logic [7:0] data_out;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl),
    .lines_busy(lines_busy), .start_det(start_det), .stop_det(stop_det),
    .addr_valid(addr_valid), .addr(addr), .rw(rw), .byte_valid(byte_valid),
    .data_out(data_out), .ack(ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 address byte, 2 data bytes, 3 ignoring.
  int       m_mode, m_nbits;
  logic [7:0] m_sh, m_data;
  logic [6:0] m_addr;
  logic     m_rw, m_ack, m_busy, m_psda, m_pscl;
  logic     e_start, e_stop, e_av, e_bv, e_err;
  logic     p_sda = 1'b1, p_scl = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_nbits = 0; m_sh = '0; m_data = '0; m_addr = '0;
    m_rw = 1'b0; m_ack = 1'b0; m_busy = 1'b0; m_psda = 1'b1; m_pscl = 1'b1;
  endtask

  // Apply the bus rules to one change of the line pair.
  task automatic model_step(input logic sda, input logic scl);
    logic in_byte;
    e_start = 0; e_stop = 0; e_av = 0; e_bv = 0; e_err = 0;
    in_byte = (m_mode == 1 || m_mode == 2) && (m_nbits != 0);
    if (m_pscl && scl && m_psda && !sda) begin
      e_start = 1; e_err = in_byte; m_busy = 1; m_mode = 1; m_nbits = 0;
    end else if (m_pscl && scl && !m_psda && sda) begin
      e_stop = 1; e_err = in_byte; m_busy = 0; m_mode = 0; m_nbits = 0;
    end else if (!m_pscl && scl && (sda == m_psda) && (m_mode == 1 || m_mode == 2)) begin
      if (m_nbits < 8) begin
        m_sh = {m_sh[6:0], sda};
        m_nbits++;
      end else begin
        m_ack = !sda;
        if (m_mode == 1) begin
          m_addr = m_sh[7:1]; m_rw = m_sh[0]; e_av = 1;
          m_mode = sda ? 3 : 2;
        end else begin
          m_data = m_sh; e_bv = 1;
        end
        m_nbits = 0;
      end
    end
    m_psda = sda; m_pscl = scl;
  endtask

  task automatic step_check();
    logic [4:0] ev;
    logic       busy_before;
    busy_before = m_busy;
    model_step(p_sda, p_scl);
    ev = {e_start, e_stop, e_av, e_bv, e_err};
    for (int k = 1; k <= PH; k++) begin
      @(posedge clk); #1;
      chk("pulses", 32'({start_det, stop_det, addr_valid, byte_valid, bus_err}),
          32'((k == LAT) ? ev : 5'b0));
      chk("lines_busy", 32'(lines_busy), 32'((k >= LAT) ? m_busy : busy_before));
      if (k == LAT && e_av) begin
        chk("addr", 32'(addr), 32'(m_addr));
        chk("rw", 32'(rw), 32'(m_rw));
        chk("ack_addr", 32'(ack), 32'(m_ack));
      end
      if (k == LAT && e_bv) begin
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("ack_data", 32'(ack), 32'(m_ack));
      end
    end
    chk("addr_held", 32'(addr), 32'(m_addr));
    chk("data_held", 32'(data_out), 32'(m_data));
  endtask

  task automatic drive(input logic sda, input logic scl);
    @(negedge clk);
    i2c_sda = sda; i2c_scl = scl; p_sda = sda; p_scl = scl;
    step_check();
  endtask

  task automatic i2c_start();
    if (p_scl && !p_sda) drive(1'b0, 1'b0);
    if (!p_scl) begin
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
    end
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    drive(b, 1'b0);
    drive(b, 1'b1);
    drive(b, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(!acked);
  endtask

  task automatic i2c_stop();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({lines_busy, start_det, stop_det, addr_valid, byte_valid, bus_err, rw, ack}), 32'd0);
    chk(tag, 32'({addr, data_out}), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] rb;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_outputs");
    @(negedge clk) rst = 1'b0;
    step_check();

    // Write 0x01: 0xCD, 0x8F, all ACKed.
    i2c_start();
    send_byte({7'h01, 1'b0}, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h8F, 1'b1);
    i2c_stop();
    chk("wr_addr", 32'(addr), 32'h01);
    chk("wr_rw", 32'(rw), 32'd0);
    chk("wr_data", 32'(data_out), 32'h8F);
    chk("wr_busy", 32'(lines_busy), 32'd0);

    // Read 0x01: 0x55 ACK, 0xF0 NACK.
    i2c_start();
    send_byte({7'h01, 1'b1}, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'hF0, 1'b0);
    i2c_stop();
    chk("rd_rw", 32'(rw), 32'd1);
    chk("rd_data", 32'(data_out), 32'hF0);
    chk("rd_ack", 32'(ack), 32'd0);

    // Write 0x01 byte 0xA5, repeated START, read 0x02.
    i2c_start();
    send_byte({7'h01, 1'b0}, 1'b1);
    send_byte(8'hA5, 1'b1);
    i2c_start();
    chk("sr_busy", 32'(lines_busy), 32'd1);
    send_byte({7'h02, 1'b1}, 1'b1);
    chk("sr_addr", 32'(addr), 32'h02);
    chk("sr_rw", 32'(rw), 32'd1);
    i2c_stop();

    // Address 0x7F NACKed, master clocks 0x3C anyway.
    i2c_start();
    send_byte({7'h7F, 1'b0}, 1'b0);
    send_byte(8'h3C, 1'b1);
    i2c_stop();
    chk("nack_ack", 32'(ack), 32'd0);
    chk("nack_data", 32'(data_out), 32'hA5);

    // STOP after 4 data bits.
    i2c_start();
    send_byte({7'h01, 1'b0}, 1'b1);
    held = data_out;
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    i2c_stop();
    chk("abort_data", 32'(data_out), 32'(held));
    chk("abort_busy", 32'(lines_busy), 32'd0);

    // Simultaneous SDA/SCL change mid-byte is ignored.
    i2c_start();
    send_byte({7'h33, 1'b0}, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    i2c_stop();

    // Reset during data bit 3.
    i2c_start();
    send_byte({7'h44, 1'b0}, 1'b1);
    send_bit(1'b1); send_bit(1'b0);
    drive(1'b0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step_check();
    for (int i = 0; i < 6; i++) send_bit(1'(i));
    i2c_stop();
    i2c_start();
    send_byte({7'h12, 1'b0}, 1'b1);
    send_byte(8'h9E, 1'b1);
    i2c_stop();

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      i2c_start();
      send_byte(8'($urandom), $urandom_range(0, 4) != 0);
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        rb = 8'($urandom);
        send_byte(rb, $urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++) send_bit(1'($urandom));
      end
      if ($urandom_range(0, 2) != 0) i2c_stop();
    end
    i2c_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each bus line (allowed 2..4).
REQ-002 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i2c_sda  input  1  bus data line, observed only, never driven.
REQ-005 SHALL have port i2c_scl  input  1  bus clock line, observed only, never driven.
REQ-006 SHALL have port lines_busy  output  1  high from START detect to STOP detect.
REQ-007 SHALL have port start_det  output  1  one-cycle pulse on START or repeated START.
REQ-008 SHALL have port stop_det  output  1  one-cycle pulse on STOP.
REQ-009 SHALL have port addr_valid  output  1  one-cycle pulse, address byte plus ACK bit complete.
REQ-010 SHALL have port addr  output  7  last decoded target address, held until next address byte.
REQ-011 SHALL have port rw  output  1  R/W bit of last address byte (1 = read).
REQ-012 SHALL have port byte_valid  output  1  one-cycle pulse, data byte plus ACK bit complete.
REQ-013 SHALL have port data_out  output  8  last decoded data byte, MSB first on the wire, held until next byte.
REQ-014 SHALL have port ack  output  1  ACK bit of last byte (1 = SDA low = ACK), valid with either valid pulse.
REQ-015 SHALL have port bus_err  output  1  one-cycle pulse on START/STOP inside a byte.

Function
REQ-016 SHALL pass both lines through SYNC_STAGES flops, then one edge-detect register; all decisions use synchronized values only.
REQ-017 SHALL detect START as synced SDA 1->0 while synced SCL is 1 in both previous and current sample; STOP as SDA 0->1 under the same SCL condition.
REQ-018 SHALL sample SDA on synced SCL 0->1; SDA changes with SCL low SHALL be ignored.
REQ-019 SHALL assert every output pulse registered, SYNC_STAGES+1 clk cycles after the causing pin edge.
REQ-020 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE with a 3-bit bit counter.
REQ-021 IDLE: START -> ADDR, counter 0, lines_busy 1; SCL edges ignored.
REQ-022 ADDR: shift 8 bits; after 8th -> ADDR_ACK; on 9th SCL rise update addr/rw/ack, pulse addr_valid; ACK -> DATA, NACK -> IGNORE.
REQ-023 DATA: shift 8 bits -> DATA_ACK; on 9th SCL rise update data_out/ack, pulse byte_valid, return to DATA regardless of ACK value.
REQ-024 IGNORE: no byte decoding; wait for START or STOP.
REQ-025 START in any non-IDLE state SHALL pulse start_det, keep lines_busy 1, go to ADDR with counter 0 (repeated START).
REQ-026 STOP in any state SHALL pulse stop_det, clear lines_busy, go to IDLE; STOP in IDLE pulses stop_det only.
REQ-027 START/STOP with counter nonzero in ADDR/DATA, or in ADDR_ACK/DATA_ACK before 9th edge, SHALL also pulse bus_err; partial byte discarded, addr/data_out unchanged.
REQ-028 Simultaneous SDA and SCL change in one synced sample SHALL be neither START/STOP nor a bit sample.

Reset
REQ-029 rst SHALL force state IDLE, counter 0, synchronizer flops to 1 (idle bus), all outputs 0, immediately and asynchronously.
REQ-030 After rst deasserts mid-transaction the block SHALL stay IDLE until a fresh START; no bus_err for the interrupted transfer.

Structure
REQ-031 Shared package i2c_pkg SHALL hold the state enum and constants I2C_ADDR_W=7, I2C_DATA_W=8.
REQ-032 One sub-module i2c_sync_edge (synchronizer + rise/fall detect, parameter SYNC_STAGES) SHALL be instantiated once per line.

Verification
REQ-033 Write addr 0x01, bytes 0xCD then 0x8F, all ACKed, STOP -> addr_valid(addr 0x01, rw 0, ack 1), byte_valid 0xCD, byte_valid 0x8F, stop_det, lines_busy 1->0.
REQ-034 Read addr 0x01, target returns 0x55 ACK then 0xF0 NACK -> rw 1, byte_valid 0x55 ack 1, byte_valid 0xF0 ack 0, then stop_det.
REQ-035 Write 0x01 byte 0xA5, repeated START, read 0x02 -> two start_det pulses, lines_busy never drops, second addr_valid shows 0x02 rw 1.
REQ-036 Address 0x7F NACKed, master clocks 0x3C anyway, STOP -> addr_valid ack 0, no byte_valid, stop_det.
REQ-037 STOP after 4 data bits -> bus_err and stop_det same cycle, data_out unchanged, state IDLE.
REQ-038 rst pulse during data bit 3 -> outputs 0 immediately; remaining SCL edges produce no pulses until next START.
